// File: rtl/drum_voice_mixer_pkg.sv
// Shared definitions for the drum voice mixer and its output-stage helpers.
// Holds default widths, the 12-bit sample limits, the shift-field width and
// the mixer state encoding.
package drum_voice_mixer_pkg;

  localparam int WIDTH_DEF     = 12;
  localparam int ACC_WIDTH_DEF = 15;
  localparam int SHIFT_W       = 2;

  localparam int SAMPLE_MAX = 2047;
  localparam int SAMPLE_MIN = -2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_t;

endpackage

// File: rtl/drum_voice_mixer_saturator.sv
// sample_saturator: combinational signed clamp from ACC_WIDTH to WIDTH.
// Ports:
//   i_acc    - signed accumulator value (ACC_WIDTH bits)
//   o_sample - i_acc clamped to the signed WIDTH-bit range
module sample_saturator
  import drum_voice_mixer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic signed [WIDTH-1:0]     o_sample
);

  // Largest positive WIDTH-bit value, held at accumulator width; its bitwise
  // complement is the most negative WIDTH-bit value.
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    ACC_WIDTH'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

  always_comb begin
    if (i_acc > MAX_V) begin
      o_sample = MAX_V[WIDTH-1:0];
    end else if (i_acc < MIN_V) begin
      o_sample = MIN_V[WIDTH-1:0];
    end else begin
      o_sample = i_acc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/drum_voice_mixer.sv
// drum_voice_mixer: on each `ready` strobe, snapshots the drum voices and
// sums the active ones (each arithmetically right-shifted by its own
// attenuation) one voice per clock through a single adder, then saturates
// to a signed WIDTH-bit sample and pulses `start` for the effect chain.
// Ports:
//   clock, reset    - system clock, asynchronous active-high reset
//   ready           - one-cycle audio-rate strobe that launches a mix
//   enable          - when low at the strobe, the mix result is forced to 0
//   voice_samples   - packed signed samples, voice i at [i*WIDTH +: WIDTH]
//   voice_active    - per-voice include flag
//   voice_shift     - per-voice 2-bit arithmetic right shift
//   clear_overrun   - synchronous clear of the sticky overrun flag
//   mixed_sample    - registered, saturated mix; holds between mixes
//   start           - one-cycle pulse when a new mixed_sample is presented
//   busy            - high while a mix is in progress
//   overrun         - sticky; a strobe arrived while busy and was dropped
module drum_voice_mixer
  import drum_voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ready,
  input  logic                          enable,
  input  logic [NUM_VOICES*WIDTH-1:0]   voice_samples,
  input  logic [NUM_VOICES-1:0]         voice_active,
  input  logic [NUM_VOICES*SHIFT_W-1:0] voice_shift,
  input  logic                          clear_overrun,
  output logic signed [WIDTH-1:0]       mixed_sample,
  output logic                          start,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t r_state;
  state_t w_next;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [IDX_W-1:0]            r_idx;

  // Snapshot taken at the launching strobe; inputs are not re-read mid-mix.
  logic signed [WIDTH-1:0]   r_samples [NUM_VOICES];
  logic [SHIFT_W-1:0]        r_shift   [NUM_VOICES];
  logic [NUM_VOICES-1:0]     r_active;
  logic                      r_enable;

  logic signed [WIDTH-1:0]     w_sel;
  logic signed [WIDTH-1:0]     w_shr;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [WIDTH-1:0]     w_sat;

  assign busy = (r_state != IDLE);

  // Current voice term: arithmetic shift floors toward minus infinity, then
  // the signed size cast sign-extends to accumulator width.
  assign w_sel  = r_samples[r_idx];
  assign w_shr  = w_sel >>> r_shift[r_idx];
  assign w_term = ACC_WIDTH'(w_shr);

  sample_saturator #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .i_acc    (r_acc),
    .o_sample (w_sat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ready) w_next = ACCUM;
      ACCUM:   if (r_idx == LAST_IDX) w_next = SAT;
      SAT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Stage p0: input snapshot at the launching strobe.
  always_ff @(posedge clock) begin
    if (r_state == IDLE && ready) begin
      r_enable <= enable;
      r_active <= voice_active;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_samples[i] <= voice_samples[i*WIDTH +: WIDTH];
        r_shift[i]   <= voice_shift[i*SHIFT_W +: SHIFT_W];
      end
    end
  end

  // Stage p1: accumulate one voice per clock, then saturate and present.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_idx        <= '0;
      mixed_sample <= '0;
      start        <= 1'b0;
    end else begin
      start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ready) begin
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ACCUM: begin
          if (r_active[r_idx]) r_acc <= r_acc + w_term;
          r_idx <= r_idx + IDX_W'(1);
        end
        SAT: begin
          mixed_sample <= r_enable ? w_sat : '0;
          start        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A strobe outside IDLE (including the SAT->IDLE edge) is dropped; a new
  // overrun beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (ready && busy) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_drum_voice_mixer.sv
// Testbench for drum_voice_mixer: directed scenarios plus randomized mixes
// checked against a plain-arithmetic reference model.
module tb_drum_voice_mixer;
  localparam int NV = 4;
  localparam int W  = 12;

  logic                clock;
  logic                reset;
  logic                ready;
  logic                enable;
  logic                clear_overrun;
  logic [NV*W-1:0]     voice_samples;
  logic [NV-1:0]       voice_active;
  logic [NV*2-1:0]     voice_shift;
  logic signed [W-1:0] mixed_sample;
  logic                start;
  logic                busy;
  logic                overrun;

  int n_tests = 0;
  int n_fail  = 0;

  drum_voice_mixer #(.NUM_VOICES(NV), .WIDTH(W), .ACC_WIDTH(15)) dut (
    .clock         (clock),
    .reset         (reset),
    .ready         (ready),
    .enable        (enable),
    .voice_samples (voice_samples),
    .voice_active  (voice_active),
    .voice_shift   (voice_shift),
    .clear_overrun (clear_overrun),
    .mixed_sample  (mixed_sample),
    .start         (start),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: sum of floor(sample / 2^shift) over active voices, clamped.
  function automatic int model(input logic [NV*W-1:0] smp, input logic [NV-1:0] act,
                               input logic [NV*2-1:0] sh, input logic en);
    int acc;
    int s;
    int d;
    acc = 0;
    for (int i = 0; i < NV; i++) begin
      s = $signed(smp[i*W +: W]);
      d = 1 << sh[i*2 +: 2];
      if (act[i]) acc += (s >= 0) ? (s / d) : -((-s + d - 1) / d);
    end
    if (acc > drum_voice_mixer_pkg::SAMPLE_MAX) acc = drum_voice_mixer_pkg::SAMPLE_MAX;
    if (acc < drum_voice_mixer_pkg::SAMPLE_MIN) acc = drum_voice_mixer_pkg::SAMPLE_MIN;
    return en ? acc : 0;
  endfunction

  function automatic logic [NV*W-1:0] pk(input int a, input int b, input int c, input int d);
    logic [W-1:0] a12, b12, c12, d12;
    a12 = a[W-1:0];
    b12 = b[W-1:0];
    c12 = c[W-1:0];
    d12 = d[W-1:0];
    return {d12, c12, b12, a12};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one mix, scramble the inputs during ACCUM, check timing and value.
  task automatic run_mix(input logic [NV*W-1:0] smp, input logic [NV-1:0] act,
                         input logic [NV*2-1:0] sh, input logic en, input string name);
    logic signed [W-1:0] e12;
    e12 = W'(model(smp, act, sh, en));
    voice_samples = smp;
    voice_active  = act;
    voice_shift   = sh;
    enable        = en;
    ready         = 1'b1;
    tick();
    ready         = 1'b0;
    voice_samples = {$urandom, $urandom};
    voice_active  = ~act;
    voice_shift   = ~sh;
    enable        = ~en;
    for (int j = 0; j < 5; j++) begin
      n_tests++;
      if (busy !== 1'b1 || start !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy/start after edge k+%0d: busy=%b start=%b, expected busy=1 start=0",
                 name, j, busy, start);
      end
      tick();
    end
    n_tests++;
    if (start !== 1'b1 || busy !== 1'b0 || mixed_sample !== e12) begin
      n_fail++;
      $display("FAIL %s result at k+5: start=%b busy=%b mixed=%0d, expected start=1 busy=0 mixed=%0d",
               name, start, busy, mixed_sample, e12);
    end
    tick();
    n_tests++;
    if (start !== 1'b0 || mixed_sample !== e12) begin
      n_fail++;
      $display("FAIL %s hold at k+6: start=%b mixed=%0d, expected start=0 mixed=%0d",
               name, start, mixed_sample, e12);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (mixed_sample !== '0 || start !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: mixed=%0d start=%b busy=%b overrun=%b, expected all 0",
               mixed_sample, start, busy, overrun);
    end
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_mix(pk(100, 200, -50, 0), 4'b1111, 8'h00, 1'b1, "basic_sum");
  endtask

  task automatic test_reset_mid_accum();
    int starts;
    voice_samples = pk(100, 200, -50, 0);
    voice_active  = 4'b1111;
    voice_shift   = 8'h00;
    enable        = 1'b1;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (mixed_sample !== '0 || start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_accum: mixed=%0d start=%b busy=%b, expected 0 0 0",
               mixed_sample, start, busy);
    end
    #2 reset = 1'b0;
    starts = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (start === 1'b1) starts++;
    end
    n_tests++;
    if (starts != 0) begin
      n_fail++;
      $display("FAIL reset_abandon: start pulses=%0d, expected 0", starts);
    end
    run_mix(pk(100, 200, -50, 0), 4'b1111, 8'h00, 1'b1, "after_reset");
  endtask

  task automatic test_saturation();
    run_mix(pk(2000, 2000, 2000, 2000), 4'b1111, 8'h00, 1'b1, "sat_pos");
    run_mix(pk(-2048, -2048, -2048, -2048), 4'b1111, 8'h00, 1'b1, "sat_neg");
    run_mix(pk(2047, 0, 0, 0), 4'b0001, 8'h00, 1'b1, "edge_max");
    run_mix(pk(-2048, 0, 0, 0), 4'b1111, 8'h00, 1'b1, "edge_min");
  endtask

  task automatic test_shift_mask();
    run_mix(pk(1024, 1024, -7, 800), 4'b0111, 8'b00_11_10_01, 1'b1, "shift_mask");
    run_mix(pk(-1, 5, 9, -100), 4'b0000, 8'h00, 1'b1, "none_active");
    run_mix(pk(-1, -1, -1, -1), 4'b1111, 8'hFF, 1'b1, "neg_floor");
  endtask

  task automatic test_enable();
    run_mix(pk(300, 400, 500, 600), 4'b1111, 8'h00, 1'b0, "enable_low");
  endtask

  task automatic test_overrun();
    int starts;
    logic signed [W-1:0] e12;
    e12 = 12'sd250;
    voice_samples = pk(100, 200, -50, 0);
    voice_active  = 4'b1111;
    voice_shift   = 8'h00;
    enable        = 1'b1;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    tick();
    voice_samples = pk(1, 1, 1, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: overrun=%b, expected 1", overrun);
    end
    starts = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (start === 1'b1) begin
        starts++;
        n_tests++;
        if (mixed_sample !== e12) begin
          n_fail++;
          $display("FAIL overrun_value: mixed=%0d, expected %0d", mixed_sample, e12);
        end
      end
    end
    n_tests++;
    if (starts != 1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_single_start: starts=%0d overrun=%b, expected 1 and 1", starts, overrun);
    end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: overrun=%b, expected 0", overrun);
    end

    // Strobe on the SAT->IDLE edge is dropped and flagged.
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_tests++;
    if (start !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_edge_ready: start=%b overrun=%b, expected 1 1", start, overrun);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_edge_dropped: busy=%b, expected 0", busy);
    end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;

    // New overrun and clear on the same edge: set wins.
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    ready = 1'b1;
    clear_overrun = 1'b1;
    tick();
    ready = 1'b0;
    clear_overrun = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clear: overrun=%b, expected 1", overrun);
    end
    for (int j = 0; j < 5; j++) tick();
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] e2;
    int cyc;
    voice_samples = pk(10, 20, 30, 40);
    voice_active  = 4'b1111;
    voice_shift   = 8'h00;
    enable        = 1'b1;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    voice_samples = pk(-500, 300, 7, 1);
    voice_active  = 4'b1011;
    voice_shift   = 8'b01_00_00_10;
    e2 = W'(model(voice_samples, voice_active, voice_shift, 1'b1));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b overrun=%b, expected 1 0", busy, overrun);
    end
    cyc = 0;
    while (start !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != 5 || mixed_sample !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d mixed=%0d, expected 5 and %0d", cyc, mixed_sample, e2);
    end
    tick();
  endtask

  task automatic test_random();
    logic [NV*W-1:0] smp;
    logic [NV-1:0]   act;
    logic [NV*2-1:0] sh;
    logic            en;
    for (int n = 0; n < 24; n++) begin
      smp = {$urandom, $urandom};
      act = NV'($urandom);
      sh  = (NV*2)'($urandom);
      en  = ($urandom_range(0, 7) != 0);
      run_mix(smp, act, sh, en, "random");
    end
  endtask

  initial begin
    reset         = 1'b1;
    ready         = 1'b0;
    enable        = 1'b0;
    clear_overrun = 1'b0;
    voice_samples = '0;
    voice_active  = '0;
    voice_shift   = '0;
    test_reset();
    test_basic();
    test_reset_mid_accum();
    test_saturation();
    test_shift_mask();
    test_enable();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
